// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART receiver and transmitter.
//   OSR          oversample ticks per bit
//   ST_*         receiver FSM state encoding (3 bits)
//   SAMP_*       sub-bit indices of the three majority-vote samples
//   calc_div()   clocks per oversample tick for a given clock and baud rate
package uart_pkg;

    localparam int OSR = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    localparam logic [3:0] SC_LAST = 4'(OSR - 1);
    localparam logic [3:0] SAMP_A  = 4'd6;
    localparam logic [3:0] SAMP_B  = 4'd7;
    localparam logic [3:0] SAMP_C  = 4'd8;

    // Truncating divide, floored at 1 so slow sim clocks still tick every cycle.
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = clk_hz / (baud * OSR);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator.
//   clk100  system clock
//   rst_p   asynchronous active-high reset
//   clr     restart the divider (phase-aligns ticks to a start edge)
//   tick    high on the cycle the divider reaches DIV-1
module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  logic clk100,
    input  logic rst_p,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk100 or posedge rst_p) begin
        if (rst_p)
            cnt <= '0;
        else if (clr || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, 16x oversampling, one-byte holding register.
//   clk100     system clock
//   rst_p      asynchronous active-high reset
//   rx_pin     asynchronous serial line, idles high
//   rx_ack     consumer has read the holding register
//   rx_data    last good byte received
//   rx_valid   holding register full, held until acked
//   frame_err  one-clock pulse when the stop bit samples low
//   overrun    sticky: a good byte was dropped because the register was full
//   busy       receiver is not idle
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk100,
    input  logic       rst_p,
    input  logic       rx_pin,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);

    logic       rx_meta_p0;
    logic       rx_s;
    logic [2:0] state;
    logic [3:0] sc;
    logic [2:0] bc;
    logic [7:0] shreg;
    logic       samp_a;
    logic       samp_b;
    logic       tick;
    logic       clr;
    logic       maj;
    logic       decide_stop;
    logic       deliver;
    logic       bad_stop;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Stage p0/p1: two-flop synchronizer, preset to the idle level
    always_ff @(posedge clk100 or posedge rst_p) begin
        if (rst_p) begin
            rx_meta_p0 <= 1'b1;
            rx_s       <= 1'b1;
        end else begin
            rx_meta_p0 <= rx_pin;
            rx_s       <= rx_meta_p0;
        end
    end

    // Divider restarts on the start edge; in BREAK it is held while the line
    // is low so leaving needs one full tick period of high line.
    assign clr = ~rx_s & ((state == ST_IDLE) | (state == ST_BREAK));

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .clk100 (clk100),
        .rst_p  (rst_p),
        .clr    (clr),
        .tick   (tick)
    );

    // The third sample is taken live, so the vote is ready on the sc=8 tick.
    assign maj         = maj3(samp_a, samp_b, rx_s);
    assign decide_stop = (state == ST_STOP) & tick & (sc == SAMP_C);
    assign deliver     = decide_stop & maj;
    assign bad_stop    = decide_stop & ~maj;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk100) begin
        if (tick && sc == SAMP_A) samp_a <= rx_s;
        if (tick && sc == SAMP_B) samp_b <= rx_s;
        if (state == ST_DATA && tick && sc == SAMP_C)
            shreg <= {maj, shreg[7:1]};
    end

    always_ff @(posedge clk100 or posedge rst_p) begin
        if (rst_p) begin
            state <= ST_IDLE;
            sc    <= '0;
            bc    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        sc    <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (sc == SAMP_B && rx_s) begin
                            state <= ST_IDLE;
                            sc    <= '0;
                        end else if (sc == SC_LAST) begin
                            state <= ST_DATA;
                            sc    <= '0;
                            bc    <= '0;
                        end else begin
                            sc <= sc + 4'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (sc == SC_LAST) begin
                            sc <= '0;
                            if (bc == 3'd7)
                                state <= ST_STOP;
                            else
                                bc <= bc + 3'd1;
                        end else begin
                            sc <= sc + 4'd1;
                        end
                    end
                end
                ST_STOP: begin
                    // Leave at mid-bit so a slightly fast sender's next start
                    // edge is not missed.
                    if (tick) begin
                        if (sc == SAMP_C) begin
                            sc    <= '0;
                            state <= maj ? ST_IDLE : ST_BREAK;
                        end else begin
                            sc <= sc + 4'd1;
                        end
                    end
                end
                ST_BREAK: begin
                    if (tick && rx_s)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage p2: holding register and status outputs
    always_ff @(posedge clk100 or posedge rst_p) begin
        if (rst_p) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            if (deliver && (!rx_valid || rx_ack)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                if (rx_ack)
                    overrun <= 1'b0;
            end else if (deliver) begin
                overrun <= 1'b1;
            end else if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    logic       clk100 = 1'b0;
    logic       rst_p;
    logic       rx_pin;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    logic       man_ack;
    logic       auto_ack;
    logic       auto_ack_pulse;
    logic       prev_valid;

    int checks = 0;
    int errors = 0;
    int rises  = 0;
    int fe_cnt = 0;

    logic [7:0] exp_q[$];

    assign rx_ack = man_ack | auto_ack_pulse;

    always #5 clk100 = ~clk100;

    uart_rx #(
        .CLK_HZ (1600000),
        .BAUD   (100000)
    ) dut (
        .clk100    (clk100),
        .rst_p     (rst_p),
        .rx_pin    (rx_pin),
        .rx_ack    (rx_ack),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: score each rx_valid rise against the queue, count
    // frame_err pulses, and optionally ack every byte.
    initial begin
        prev_valid     = 1'b0;
        auto_ack_pulse = 1'b0;
        forever begin
            @(negedge clk100);
            if (rx_valid && !prev_valid) begin
                logic [8:0] exp9;
                rises++;
                exp9 = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
                check("rx_data", {23'b0, 1'b0, rx_data}, {23'b0, exp9});
            end
            if (frame_err) fe_cnt++;
            auto_ack_pulse = auto_ack && rx_valid && !auto_ack_pulse;
            prev_valid     = rx_valid;
        end
    end

    // One slot = one clock; a bit is 16 slots. Glitch pulls one slot low
    // in the middle of the chosen data bit.
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit,
                               input int glitch_bit, input int max_slots);
        logic [9:0] frame;
        int slot;
        frame = {stop_bit, b, 1'b0};
        slot  = 0;
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < 16; k++) begin
                if (slot >= max_slots) return;
                @(negedge clk100);
                rx_pin = ((i - 1) == glitch_bit && k == 8) ? 1'b0 : frame[i];
                slot++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk100);
            rx_pin = 1'b1;
        end
    endtask

    initial begin
        int r0;
        int f0;
        logic saw_busy;

        rst_p    = 1'b1;
        rx_pin   = 1'b1;
        man_ack  = 1'b0;
        auto_ack = 1'b0;
        repeat (3) @(negedge clk100);
        check("rst_data", {24'b0, rx_data}, 32'h0);
        check("rst_valid", {31'b0, rx_valid}, 32'h0);
        check("rst_ferr", {31'b0, frame_err}, 32'h0);
        check("rst_ovr", {31'b0, overrun}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        rst_p = 1'b0;
        idle(5);

        // Back-to-back bytes, acked
        auto_ack = 1'b1;
        r0 = rises;
        exp_q.push_back(8'h55);
        drive_frame(8'h55, 1'b1, -5, 160);
        exp_q.push_back(8'hA3);
        drive_frame(8'hA3, 1'b1, -5, 160);
        idle(24);
        check("b2b_rises", rises - r0, 2);
        check("b2b_ferr", fe_cnt, 0);
        check("b2b_ovr", {31'b0, overrun}, 32'h0);
        check("b2b_valid", {31'b0, rx_valid}, 32'h0);
        check("b2b_q", exp_q.size(), 0);

        // Single-clock glitch on data bit 2
        r0 = rises;
        exp_q.push_back(8'h3C);
        drive_frame(8'h3C, 1'b1, 2, 160);
        idle(24);
        check("glitch_rises", rises - r0, 1);
        check("glitch_q", exp_q.size(), 0);

        // False start
        r0 = rises;
        saw_busy = 1'b0;
        repeat (4) begin
            @(negedge clk100);
            rx_pin = 1'b0;
            if (busy) saw_busy = 1'b1;
        end
        repeat (20) begin
            @(negedge clk100);
            rx_pin = 1'b1;
            if (busy) saw_busy = 1'b1;
        end
        check("fs_busy_seen", {31'b0, saw_busy}, 32'h1);
        check("fs_busy_end", {31'b0, busy}, 32'h0);
        check("fs_rises", rises - r0, 0);
        check("fs_ferr", fe_cnt, 0);

        // Bad stop bit followed by a long break
        r0 = rises;
        f0 = fe_cnt;
        drive_frame(8'h81, 1'b0, -5, 160);
        repeat (80) begin
            @(negedge clk100);
            rx_pin = 1'b0;
        end
        idle(16);
        check("brk_ferr", fe_cnt - f0, 1);
        check("brk_rises", rises - r0, 0);
        check("brk_valid", {31'b0, rx_valid}, 32'h0);
        exp_q.push_back(8'h7E);
        drive_frame(8'h7E, 1'b1, -5, 160);
        idle(24);
        check("brk_next_rises", rises - r0, 1);
        check("brk_next_ferr", fe_cnt - f0, 1);
        check("brk_q", exp_q.size(), 0);

        // Overrun
        auto_ack = 1'b0;
        r0 = rises;
        exp_q.push_back(8'h11);
        drive_frame(8'h11, 1'b1, -5, 160);
        drive_frame(8'h22, 1'b1, -5, 160);
        idle(24);
        check("ovr_data", {24'b0, rx_data}, 32'h11);
        check("ovr_valid", {31'b0, rx_valid}, 32'h1);
        check("ovr_flag", {31'b0, overrun}, 32'h1);
        check("ovr_rises", rises - r0, 1);
        @(negedge clk100);
        man_ack = 1'b1;
        @(negedge clk100);
        man_ack = 1'b0;
        @(negedge clk100);
        check("ack_valid", {31'b0, rx_valid}, 32'h0);
        check("ack_ovr", {31'b0, overrun}, 32'h0);
        auto_ack = 1'b1;

        // Reset mid-frame during data bit 4
        r0 = rises;
        f0 = fe_cnt;
        drive_frame(8'hF0, 1'b1, -5, 16 + 16 * 4 + 8);
        @(negedge clk100);
        rst_p  = 1'b1;
        rx_pin = 1'b1;
        repeat (3) @(negedge clk100);
        check("mid_rst_outs", {19'b0, rx_data, rx_valid, frame_err, overrun, busy}, 32'h0);
        rst_p = 1'b0;
        idle(20);
        check("post_rst_rises", rises - r0, 0);
        check("post_rst_busy", {31'b0, busy}, 32'h0);
        exp_q.push_back(8'h0F);
        drive_frame(8'h0F, 1'b1, -5, 160);
        idle(24);
        check("rst_next_rises", rises - r0, 1);
        check("rst_next_ferr", fe_cnt - f0, 0);
        check("final_q", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
